imm_gen: RTL and testbench
==========================

Name: imm_gen

Overview:
RV32I immediate generator for the decode stage of the single-issue core. It extracts the immediate field of a 32-bit instruction and sign-extends it, using the format selector driven by the main decoder. The primary output `imm_ext` is purely combinational, for same-cycle use by the ALU operand mux and branch/jump target adders. A registered copy is also provided for pipelined datapaths.

Parameters:
XLEN, 32, instruction and immediate width; only 32 is supported.

Ports:
clk  input  1  system clock; used only by the registered output stage
rst_n  input  1  asynchronous active-low reset
instruction  input  32  raw instruction word
imm_src  input  3  immediate format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101/110/111 none
imm_ext  output  32  combinational sign-extended immediate
imm_valid  output  1  combinational; 1 when imm_src is in 000..100
imm_ext_q  output  32  imm_ext registered on the rising edge of clk
imm_valid_q  output  1  imm_valid registered on the rising edge of clk

Behaviour:
- imm_ext is a pure function of instruction and imm_src. No clock involvement; it must settle within the same delta/cycle.
- I-type (000): bits 31..11 = instr[31] replicated, bits 10..0 = instr[30:20].
- S-type (001): bits 31..11 = instr[31] replicated, then instr[30:25], then instr[11:7].
- B-type (010): bits 31..12 = instr[31] replicated, bit 11 = instr[7], then instr[30:25], then instr[11:8], bit 0 = 0.
- U-type (011): instr[31:12] followed by 12 zero bits.
- J-type (100): bits 31..20 = instr[31] replicated, then instr[19:12], then instr[20], then instr[30:21], bit 0 = 0.
- imm_src 101, 110 and 111: imm_ext = 0 and imm_valid = 0. No X propagation for any select value.
- X/Z on instruction bits not used by the selected format must not affect imm_ext.
- Registered stage: on the rising edge of clk, imm_ext_q <= imm_ext and imm_valid_q <= imm_valid.
  - Latency is 1 cycle.
  - No enable; the stage updates every cycle.
- Reset: while rst_n is low, imm_ext_q = 0 and imm_valid_q = 0, asynchronously and immediately.
  - Reset deassertion is synchronous to clk internally; the first capture happens on the first rising edge after deassertion.
  - Reset asserted mid-operation clears only the registered outputs. imm_ext and imm_valid stay combinational and unaffected by reset.
- No internal state other than the two output registers. No handshake.

Decomposition:
- Shared core package: imm_src encodings as a 3-bit enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J), XLEN, and the opcode constants used by the main decoder to drive imm_src.
- One optional combinational sub-module, imm_gen_comb, holding the format mux. The top imm_gen wraps it and adds the output register stage.

Test Plan:
- I-type: instruction=FFF12383, imm_src=000 -> imm_ext=FFFFFFFF, imm_valid=1. Also instruction=7FF00013 -> 000007FF.
- S-type: instruction=00F12323, imm_src=001 -> 00000006. B-type: instruction=FE512EE3, imm_src=010 -> FFFFFFFC.
- U-type: instruction=12345037, imm_src=011 -> 12345000. J-type: instruction=FFF0016F, imm_src=100 -> FFF00FFE.
- Undefined selects: imm_src=101, 110 and 111, each with any instruction (e.g. FFFFFFFF) -> imm_ext=00000000, imm_valid=0.
- Registered path: apply the U-type vector, then clock -> imm_ext_q=12345000 and imm_valid_q=1 one cycle later. Change inputs mid-cycle -> imm_ext_q holds until the next edge.
- Reset: assert rst_n=0 between clock edges -> imm_ext_q=0 and imm_valid_q=0 immediately, while imm_ext still reflects the inputs. Release rst_n -> capture resumes on the next rising edge.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared decode definitions: immediate format selects, datapath width and the
// base-opcode constants the main decoder uses to pick an immediate format.
package imm_gen_pkg;

   localparam int unsigned XLEN = 32;

   // Immediate format select driven by the main decoder
   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } imm_src_e;

   // Select used by the decoder for instructions that carry no immediate
   localparam logic [2:0] IMM_NONE = 3'b111;

   // RV32I base opcodes (instr[6:0])
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // True for the five defined formats; 101..111 carry no immediate
   function automatic logic imm_src_valid(input logic [2:0] src);
      return (src <= 3'(IMM_J));
   endfunction

   // Format select the main decoder drives for a given base opcode
   function automatic logic [2:0] imm_src_for_opcode(input logic [6:0] opcode);
      logic [2:0] src;
      src = IMM_NONE;
      case (opcode)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: src = 3'(IMM_I);
         OPC_STORE:                                  src = 3'(IMM_S);
         OPC_BRANCH:                                 src = 3'(IMM_B);
         OPC_LUI, OPC_AUIPC:                         src = 3'(IMM_U);
         OPC_JAL:                                    src = 3'(IMM_J);
         default:                                    src = IMM_NONE;
      endcase
      return src;
   endfunction

endpackage

// File: rtl/imm_gen_comb.sv
// Combinational RV32I immediate format mux with sign extension.
module imm_gen_comb #(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     instruction,
   input  logic [2:0]      imm_src,
   output logic [XLEN-1:0] imm_ext,
   output logic            imm_valid
);
   import imm_gen_pkg::*;

   // Select and sign-extend the immediate; only bits of the chosen format are read,
   // so unknowns on unused instruction bits never reach the output
   always_comb begin
      imm_ext   = '0;
      imm_valid = imm_src_valid(imm_src);
      case (imm_src)
         IMM_I: imm_ext = {{21{instruction[31]}}, instruction[30:20]};
         IMM_S: imm_ext = {{21{instruction[31]}}, instruction[30:25], instruction[11:7]};
         IMM_B: imm_ext = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                           instruction[11:8], 1'b0};
         IMM_U: imm_ext = {instruction[31:12], 12'b0};
         IMM_J: imm_ext = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                           instruction[30:21], 1'b0};
         default: imm_ext = '0;
      endcase
   end

endmodule

// File: rtl/imm_gen.sv
// Decode-stage immediate generator: combinational result for same-cycle use plus
// a one-cycle registered copy for pipelined datapaths.
module imm_gen #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     instruction,
   input  logic [2:0]      imm_src,
   output logic [XLEN-1:0] imm_ext,
   output logic            imm_valid,
   output logic [XLEN-1:0] imm_ext_q,
   output logic            imm_valid_q
);

   imm_gen_comb #(
      .XLEN (XLEN)
   ) u_comb (
      .instruction (instruction),
      .imm_src     (imm_src),
      .imm_ext     (imm_ext),
      .imm_valid   (imm_valid)
   );

   // Register the combinational result every cycle; reset clears only this stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imm_ext_q   <= '0;
         imm_valid_q <= 1'b0;
      end else begin
         imm_ext_q   <= imm_ext;
         imm_valid_q <= imm_valid;
      end
   end

endmodule

// File: tb/tb_imm_gen.sv
// Scoreboard bench for imm_gen: a driver pushes model results, separate monitors
// compare the combinational and registered outputs.
module tb_imm_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instruction;
   logic [2:0]  imm_src;
   logic [31:0] imm_ext;
   logic        imm_valid;
   logic [31:0] imm_ext_q;
   logic        imm_valid_q;

   typedef struct packed {
      logic [31:0] ext;
      logic        valid;
   } exp_t;

   exp_t comb_q[$];
   exp_t reg_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   imm_gen #(
      .XLEN (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instruction (instruction),
      .imm_src     (imm_src),
      .imm_ext     (imm_ext),
      .imm_valid   (imm_valid),
      .imm_ext_q   (imm_ext_q),
      .imm_valid_q (imm_valid_q)
   );

   always #5 clk = ~clk;

   // Immediate value as the ISA defines it: a signed field, scaled for branch/jump
   function automatic exp_t model(input logic [31:0] ins, input logic [2:0] sel);
      exp_t e;
      int   v;
      case (sel)
         3'd0: v = 32'($signed(ins[31:20]));
         3'd1: v = 32'($signed({ins[31:25], ins[11:7]}));
         3'd2: v = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
         3'd3: v = int'(ins[31:12]) * 4096;
         3'd4: v = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
         default: v = 0;
      endcase
      e.ext   = 32'(v);
      e.valid = (sel < 3'd5);
      return e;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, req);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0b, expected %0b", name, act, req);
      end
   endtask

   // Drive one vector at the falling edge and record what both outputs owe
   task automatic apply(input logic [31:0] ins, input logic [2:0] sel);
      exp_t e;
      @(negedge clk);
      instruction = ins;
      imm_src     = sel;
      e = model(ins, sel);
      comb_q.push_back(e);
      reg_q.push_back(e);
   endtask

   // Combinational monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            check32("imm_ext", imm_ext, e.ext);
            check1("imm_valid", imm_valid, e.valid);
         end
      end
   end

   // Registered monitor: each vector must appear one rising edge after it was driven
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            check32("imm_ext_q", imm_ext_q, e.ext);
            check1("imm_valid_q", imm_valid_q, e.valid);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   logic [31:0] dir_ins [9] = '{32'hFFF12383, 32'h7FF00013, 32'h00F12323, 32'hFE512EE3,
                                32'h12345037, 32'hFFF0016F, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFFFF};
   logic [2:0]  dir_sel [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
   logic [31:0] dir_exp [9] = '{32'hFFFFFFFF, 32'h000007FF, 32'h00000006, 32'hFFFFFFFC,
                                32'h12345000, 32'hFFF00FFE, 32'h0, 32'h0, 32'h0};

   initial begin
      int budget;
      rst_n       = 1'b0;
      instruction = '0;
      imm_src     = '0;
      #1;
      check32("reset imm_ext_q", imm_ext_q, 32'h0);
      check1("reset imm_valid_q", imm_valid_q, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Known-answer vectors, checked directly against hand-computed values
      for (int i = 0; i < 9; i++) begin
         apply(dir_ins[i], dir_sel[i]);
         #1;
         check32("known imm_ext", imm_ext, dir_exp[i]);
      end

      // Random vectors across all select codes
      for (int i = 0; i < 300; i++) begin
         apply($urandom, 3'($urandom_range(0, 7)));
      end

      // Let the monitors drain within a bounded number of cycles
      budget = 10;
      while ((comb_q.size() > 0 || reg_q.size() > 0) && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      n_checks++;
      if (comb_q.size() > 0 || reg_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", comb_q.size() + reg_q.size());
      end

      // Hold: registered copy keeps its value when inputs change mid-cycle
      apply(32'h12345037, 3'd3);
      @(posedge clk);
      #2;
      instruction = 32'hFFF12383;
      imm_src     = 3'd0;
      #1;
      check32("hold imm_ext_q", imm_ext_q, 32'h12345000);
      check1("hold imm_valid_q", imm_valid_q, 1'b1);
      check32("hold imm_ext new", imm_ext, 32'hFFFFFFFF);

      // Asynchronous reset between edges clears only the registered stage
      @(posedge clk);
      #2;
      instruction = 32'h12345037;
      imm_src     = 3'd3;
      #1;
      rst_n = 1'b0;
      #1;
      check32("async rst imm_ext_q", imm_ext_q, 32'h0);
      check1("async rst imm_valid_q", imm_valid_q, 1'b0);
      check32("async rst imm_ext", imm_ext, 32'h12345000);
      check1("async rst imm_valid", imm_valid, 1'b1);
      @(posedge clk);
      #1;
      check32("rst held imm_ext_q", imm_ext_q, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check32("rst released imm_ext_q", imm_ext_q, 32'h0);
      @(posedge clk);
      #1;
      check32("first capture imm_ext_q", imm_ext_q, 32'h12345000);
      check1("first capture imm_valid_q", imm_valid_q, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
